// File: rtl/argmax_16_16.sv
// argmax_16_16: streaming argmax over M-element signed vectors.
// Accepts one element per handshake and returns the index and value of
// the largest element once per vector. On ties the lowest index wins.
module argmax_16_16 #(
    parameter  int M         = 16,
    parameter  int T         = 16,
    localparam int LOGSIZE_M = $clog2(M)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [T-1:0]         input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [LOGSIZE_M-1:0] output_index,
    output logic [T-1:0]         output_data
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [LOGSIZE_M-1:0] CNT_LAST = LOGSIZE_M'(M - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LOGSIZE_M-1:0]   r_cnt;
    logic [T-1:0]           r_max_val;
    logic [LOGSIZE_M-1:0]   r_max_idx;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_gt;

    // Accept is decoded from state, not from input_ready, so the handshake
    // never forms a combinational loop through the output decode.
    assign w_accept = input_valid && (r_state == ACCUM);
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_gt     = $signed(input_data) > $signed(r_max_val);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ACCUM;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs, decoded from state only.
    always_comb begin
        w_state_nxt  = r_state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                input_ready = 1'b1;
                if (w_accept && w_last) w_state_nxt = HOLD;
            end
            HOLD: begin
                output_valid = 1'b1;
                if (output_ready) w_state_nxt = ACCUM;
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Running maximum and element counter; element 0 always seeds the max,
    // later elements replace it only when strictly greater.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            if (r_cnt == '0) begin
                r_max_val <= input_data;
                r_max_idx <= '0;
            end else if (w_gt) begin
                r_max_val <= input_data;
                r_max_idx <= r_cnt;
            end
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Result is held in the max registers until the downstream handshake.
    assign output_index = r_max_idx;
    assign output_data  = r_max_val;

endmodule

// File: tb/tb_argmax_16_16.sv
// Bench for argmax_16_16: directed vector table, hand-written multi-cycle
// sequences (stall, reset abort, back-to-back) and random vectors checked
// against a simple argmax model.
module tb_argmax_16_16;
    localparam int M = 16;
    localparam int T = 16;

    typedef logic signed [T-1:0] vec_t [M];

    typedef struct {
        string          name;
        vec_t           v;
        bit             gap;
        int             eidx;
        int             edata;
    } vrec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         input_valid;
    logic         input_ready;
    logic [T-1:0] input_data;
    logic         output_valid;
    logic         output_ready;
    logic [3:0]   output_index;
    logic [T-1:0] output_data;

    int total = 0;
    int bad   = 0;

    argmax_16_16 #(.M(M), .T(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_index (output_index),
        .output_data  (output_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: first occurrence of the largest signed value.
    function automatic int ref_idx(input vec_t v);
        int best = 0;
        for (int i = 1; i < M; i++)
            if (int'(v[i]) > int'(v[best])) best = i;
        return best;
    endfunction

    // Drive one vector, optionally with a bubble before each element; the
    // result must appear exactly one cycle after the last accept.
    task automatic push(input vec_t v, input bit gap);
        for (int i = 0; i < M; i++) begin
            if (gap) begin
                input_valid = 1'b0;
                input_data  = 16'h7fff;
                @(posedge clk); #1;
            end
            if (i == M - 1) chk("no_early_valid", int'(output_valid), 0);
            input_valid = 1'b1;
            input_data  = v[i];
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        chk("latency_valid", int'(output_valid), 1);
    endtask

    // Check the pending result, complete the handshake for one cycle.
    task automatic collect(input string nm, input int eidx, input int edata);
        chk({nm, "_valid"}, int'(output_valid), 1);
        chk({nm, "_in_rdy_low"}, int'(input_ready), 0);
        chk({nm, "_index"}, int'(output_index), eidx);
        chk({nm, "_data"}, int'($signed(output_data)), edata);
        output_ready = 1'b1;
        @(posedge clk); #1;
        output_ready = 1'b0;
        chk({nm, "_in_rdy_back"}, int'(input_ready), 1);
        chk({nm, "_valid_drop"}, int'(output_valid), 0);
    endtask

    initial begin
        vrec_t tbl [4];
        vec_t  a, b;

        for (int i = 0; i < M; i++) begin
            tbl[0].v[i] = T'(3 * i - 5);
            tbl[1].v[i] = -16'sd7;
            tbl[2].v[i] = 16'sh8000;
            tbl[3].v[i] = (i == 9) ? -16'sd1 : -16'sd100;
        end
        tbl[0].name = "ascending"; tbl[0].gap = 0; tbl[0].eidx = 15; tbl[0].edata = 40;
        tbl[1].name = "tie_m7";    tbl[1].gap = 0; tbl[1].eidx = 0;  tbl[1].edata = -7;
        tbl[2].name = "all_min";   tbl[2].gap = 0; tbl[2].eidx = 0;  tbl[2].edata = -32768;
        tbl[3].name = "bubbles";   tbl[3].gap = 1; tbl[3].eidx = 9;  tbl[3].edata = -1;

        reset = 1'b1; input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", int'(input_ready), 1);
        chk("rst_out_valid", int'(output_valid), 0);
        chk("rst_index", int'(output_index), 0);
        chk("rst_data", int'(output_data), 0);
        reset = 1'b0;

        // Directed table.
        for (int k = 0; k < 4; k++) begin
            push(tbl[k].v, tbl[k].gap);
            collect(tbl[k].name, tbl[k].eidx, tbl[k].edata);
        end

        // Result stalled 5 cycles with input_valid high: nothing consumed.
        // The stalled element is 0x7fff, so consuming it would corrupt b.
        push(tbl[0].v, 1'b0);
        input_valid = 1'b1;
        input_data  = 16'h7fff;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_index", int'(output_index), 15);
            chk("stall_data", int'($signed(output_data)), 40);
            chk("stall_in_rdy", int'(input_ready), 0);
        end
        collect("stall", 15, 40);
        for (int i = 0; i < M; i++) b[i] = (i == 3) ? 16'sd50 : T'(i - 20);
        push(b, 1'b0);
        collect("after_stall", 3, 50);

        // Reset mid-vector discards the partial maximum 99.
        for (int i = 0; i < 7; i++) begin
            input_valid = 1'b1;
            input_data  = (i == 2) ? 16'd99 : 16'd1;
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", int'(output_valid), 0);
        chk("abort_in_rdy", int'(input_ready), 1);
        chk("abort_data", int'(output_data), 0);
        for (int i = 0; i < M; i++) b[i] = (i == 11) ? 16'sd12 : T'(-i);
        push(b, 1'b0);
        collect("after_abort", 11, 12);

        // Back-to-back vectors at full throughput.
        for (int i = 0; i < M; i++) begin
            a[i] = T'($urandom);
            b[i] = T'($urandom);
        end
        push(a, 1'b0);
        collect("b2b_0", ref_idx(a), int'(a[ref_idx(a)]));
        push(b, 1'b0);
        collect("b2b_1", ref_idx(b), int'(b[ref_idx(b)]));

        // Random vectors; narrow ranges force ties.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < M; i++)
                a[i] = (n % 2 == 0) ? T'($urandom) : T'(int'($urandom_range(0, 4)) - 2);
            push(a, bit'($urandom_range(0, 1)));
            collect("rand", ref_idx(a), int'(a[ref_idx(a)]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
